coin_acceptor: RTL and testbench

Front end of the vending machine's money path: accepts coins one at a time, accumulates credit against a latched item price, and keeps a per-denomination coin inventory. When credit reaches the price, or the customer cancels, it computes the amount owed back and holds `done_money_in` / `change_back` for the change-making block. It then reconciles the inventory with the coins that block reports as dispensed. It also drives the `is_there_coin` availability vector consumed by the change maker.

---
 rtl/coin_acceptor.sv | 132 +++++++++++++
 tb/tb_coin_acceptor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_acceptor.sv
// Coin intake for the vending machine money path: accumulates credit against a
// latched price and keeps a per-denomination coin inventory.
module coin_acceptor #(
    parameter logic [7:0] MAX_CREDIT = 8'd250,
    parameter logic [3:0] STOCK_INIT = 4'd5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] price,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       cancel,
    input  logic       done_change_maker,
    input  logic [3:0] half_dollar,
    input  logic [3:0] quarter,
    input  logic [3:0] dime,
    input  logic [3:0] nickel,
    output logic [7:0] credit,
    output logic [7:0] change_back,
    output logic       done_money_in,
    output logic [3:0] is_there_coin,
    output logic       coin_rejected,
    output logic       busy
);
    localparam int unsigned NUM_DENOM = 4;

    typedef enum logic [1:0] {IDLE, COLLECT, PAID} state_t;

    state_t     state;
    logic [7:0] price_q;
    logic       dcm_q;
    logic [3:0] stock     [NUM_DENOM];
    logic [3:0] dispensed [NUM_DENOM];
    logic [7:0] coin_val;
    logic [8:0] sum;
    logic       coin_ok;
    logic [7:0] new_credit;
    logic       dcm_rise;

    always_comb begin
        case (coin_type)
            2'd0:    coin_val = 8'd5;
            2'd1:    coin_val = 8'd10;
            2'd2:    coin_val = 8'd25;
            default: coin_val = 8'd50;
        endcase
    end

    assign dispensed[0] = nickel;
    assign dispensed[1] = dime;
    assign dispensed[2] = quarter;
    assign dispensed[3] = half_dollar;

    // 9-bit sum so the ceiling check cannot wrap
    assign sum        = 9'(credit) + 9'(coin_val);
    assign coin_ok    = coin_valid && (sum <= 9'(MAX_CREDIT)) && (stock[coin_type] != 4'hF);
    assign new_credit = coin_ok ? sum[7:0] : credit;
    assign dcm_rise   = done_change_maker && !dcm_q;

    always_comb begin
        is_there_coin = '0;
        for (int i = 0; i < NUM_DENOM; i++) begin
            is_there_coin[i] = (stock[i] != 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            price_q       <= '0;
            dcm_q         <= 1'b0;
            credit        <= '0;
            change_back   <= '0;
            done_money_in <= 1'b0;
            coin_rejected <= 1'b0;
            busy          <= 1'b0;
            for (int i = 0; i < NUM_DENOM; i++) begin
                stock[i] <= STOCK_INIT;
            end
        end else begin
            dcm_q         <= done_change_maker;
            coin_rejected <= 1'b0;
            case (state)
                IDLE: begin
                    coin_rejected <= coin_valid;
                    if (start && (price != 8'd0) && (price <= MAX_CREDIT)) begin
                        price_q <= price;
                        busy    <= 1'b1;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    coin_rejected <= coin_valid && !coin_ok;
                    credit        <= new_credit;
                    if (coin_ok) begin
                        stock[coin_type] <= stock[coin_type] + 4'd1;
                    end
                    // cancel takes the coin of the same cycle into the refund
                    if (cancel) begin
                        if (new_credit != 8'd0) begin
                            change_back   <= new_credit;
                            done_money_in <= 1'b1;
                            state         <= PAID;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (coin_ok && (new_credit >= price_q)) begin
                        change_back   <= new_credit - price_q;
                        done_money_in <= 1'b1;
                        state         <= PAID;
                    end
                end
                PAID: begin
                    coin_rejected <= coin_valid;
                    if (dcm_rise) begin
                        for (int i = 0; i < NUM_DENOM; i++) begin
                            stock[i] <= (stock[i] >= dispensed[i]) ? stock[i] - dispensed[i] : 4'd0;
                        end
                        credit        <= '0;
                        change_back   <= '0;
                        done_money_in <= 1'b0;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_coin_acceptor;
    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] price;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       cancel;
    logic       done_change_maker;
    logic [3:0] half_dollar, quarter, dime, nickel;
    logic [7:0] credit, change_back;
    logic       done_money_in;
    logic [3:0] is_there_coin;
    logic       coin_rejected;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // model: phase 0 = waiting, 1 = collecting, 2 = paid
    int m_phase, m_credit, m_price, m_change, m_prev_dcm, m_rej;
    int m_stock [4];

    coin_acceptor dut (
        .clock(clock), .reset(reset), .start(start), .price(price),
        .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
        .done_change_maker(done_change_maker), .half_dollar(half_dollar),
        .quarter(quarter), .dime(dime), .nickel(nickel), .credit(credit),
        .change_back(change_back), .done_money_in(done_money_in),
        .is_there_coin(is_there_coin), .coin_rejected(coin_rejected), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic int value_of(input int t);
        int vals [4] = '{5, 10, 25, 50};
        return vals[t];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model, advanced once per rising edge from the sampled inputs
    always @(posedge clock) begin
        int ph, cr, pr, chg, rej, v, ct;
        int st [4];
        int disp [4];
        bit rise;
        ph = m_phase; cr = m_credit; pr = m_price; chg = m_change; rej = 0;
        for (int i = 0; i < 4; i++) st[i] = m_stock[i];
        disp[0] = int'(nickel); disp[1] = int'(dime);
        disp[2] = int'(quarter); disp[3] = int'(half_dollar);
        if (reset) begin
            ph = 0; cr = 0; pr = 0; chg = 0;
            for (int i = 0; i < 4; i++) st[i] = 5;
            m_prev_dcm <= 0;
        end else begin
            rise = done_change_maker && (m_prev_dcm == 0);
            m_prev_dcm <= int'(done_change_maker);
            if (ph == 0) begin
                rej = int'(coin_valid);
                if (start && price > 0 && price <= 250) begin
                    pr = int'(price);
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (coin_valid) begin
                    ct = int'(coin_type);
                    v = value_of(ct);
                    if (cr + v > 250 || st[ct] == 15) rej = 1;
                    else begin
                        cr += v;
                        st[ct] += 1;
                    end
                end
                if (cancel) begin
                    if (cr > 0) begin chg = cr; ph = 2; end
                    else ph = 0;
                end else if (cr >= pr) begin
                    chg = cr - pr;
                    ph = 2;
                end
            end else begin
                rej = int'(coin_valid);
                if (rise) begin
                    for (int i = 0; i < 4; i++) st[i] = (st[i] > disp[i]) ? st[i] - disp[i] : 0;
                    cr = 0; chg = 0; ph = 0;
                end
            end
        end
        m_phase <= ph; m_credit <= cr; m_price <= pr; m_change <= chg; m_rej <= rej;
        for (int i = 0; i < 4; i++) m_stock[i] <= st[i];
    end

    // per-cycle comparison, away from the active edge
    always @(negedge clock) begin
        if (chk_on) begin
            int itc, stk;
            itc = 0;
            stk = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_stock[i] != 0) itc |= (1 << i);
                stk |= (m_stock[i] << (4 * i));
            end
            chk("credit", int'(credit), m_credit);
            chk("change_back", int'(change_back), (m_phase == 2) ? m_change : 0);
            chk("done_money_in", int'(done_money_in), (m_phase == 2) ? 1 : 0);
            chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
            chk("coin_rejected", int'(coin_rejected), m_rej);
            chk("is_there_coin", int'(is_there_coin), itc);
            chk("stock", int'({dut.stock[3], dut.stock[2], dut.stock[1], dut.stock[0]}), stk);
        end
    end

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; price = 8'd0; coin_valid = 1'b0; coin_type = 2'd0;
        cancel = 1'b0; done_change_maker = 1'b0;
        half_dollar = 4'd0; quarter = 4'd0; dime = 4'd0; nickel = 4'd0;
        step(); step();
        reset = 1'b0;
        chk_on = 1'b1;
        chk("rst_credit", int'(credit), 0);
        chk("rst_done", int'(done_money_in), 0);
        chk("rst_change", int'(change_back), 0);
        chk("rst_itc", int'(is_there_coin), 15);
        chk("rst_busy", int'(busy), 0);

        // price 65, three quarters
        start = 1'b1; price = 8'd65; step(); start = 1'b0;
        coin_valid = 1'b1; coin_type = 2'd2; step();
        chk("q1_credit", int'(credit), 25); step();
        chk("q2_credit", int'(credit), 50); step();
        coin_valid = 1'b0;
        chk("q3_credit", int'(credit), 75);
        chk("q3_done", int'(done_money_in), 1);
        chk("q3_change", int'(change_back), 10);
        chk("q3_qstock", int'(dut.stock[2]), 8);
        done_change_maker = 1'b1; step();
        chk("q_exit_done", int'(done_money_in), 0);
        done_change_maker = 1'b0; step();

        // price 30, half dollar, two dimes dispensed
        start = 1'b1; price = 8'd30; step(); start = 1'b0;
        coin_valid = 1'b1; coin_type = 2'd3; step(); coin_valid = 1'b0;
        chk("h_change", int'(change_back), 20);
        chk("h_done", int'(done_money_in), 1);
        dime = 4'd2; done_change_maker = 1'b1; step(); dime = 4'd0;
        chk("h_exit_done", int'(done_money_in), 0);
        chk("h_exit_busy", int'(busy), 0);
        chk("h_dstock", int'(dut.stock[1]), 3);

        // overlap: done_change_maker still high from the previous transaction
        start = 1'b1; price = 8'd10; step(); start = 1'b0;
        coin_valid = 1'b1; coin_type = 2'd1; step(); coin_valid = 1'b0;
        chk("ov_done", int'(done_money_in), 1);
        step(); step(); step();
        chk("ov_held", int'(done_money_in), 1);
        done_change_maker = 1'b0; step();
        chk("ov_low", int'(done_money_in), 1);
        done_change_maker = 1'b1; step();
        chk("ov_exit", int'(done_money_in), 0);
        done_change_maker = 1'b0;

        // nickel stock saturates at 15, then cancel refunds 50
        start = 1'b1; price = 8'd100; step(); start = 1'b0;
        coin_valid = 1'b1; coin_type = 2'd0;
        repeat (10) step();
        chk("n_credit", int'(credit), 50);
        step(); coin_valid = 1'b0;
        chk("n_rej", int'(coin_rejected), 1);
        chk("n_credit_hold", int'(credit), 50);
        chk("n_stock", int'(dut.stock[0]), 15);
        step();
        chk("n_rej_pulse", int'(coin_rejected), 0);
        cancel = 1'b1; step(); cancel = 1'b0;
        chk("n_refund", int'(change_back), 50);
        nickel = 4'd10; done_change_maker = 1'b1; step(); nickel = 4'd0;
        chk("n_stock_back", int'(dut.stock[0]), 5);
        done_change_maker = 1'b0;

        // coin in IDLE, out-of-range start
        coin_valid = 1'b1; coin_type = 2'd1; step(); coin_valid = 1'b0;
        chk("idle_rej", int'(coin_rejected), 1);
        start = 1'b1; price = 8'd255; step(); start = 1'b0;
        chk("p255_busy", int'(busy), 0);

        // dime + nickel then cancel
        start = 1'b1; price = 8'd100; step(); start = 1'b0;
        coin_valid = 1'b1; coin_type = 2'd1; step();
        coin_type = 2'd0; step(); coin_valid = 1'b0;
        cancel = 1'b1; step(); cancel = 1'b0;
        chk("c_change", int'(change_back), 15);
        chk("c_done", int'(done_money_in), 1);
        done_change_maker = 1'b1; step(); done_change_maker = 1'b0; step();

        // cancel with zero credit
        start = 1'b1; price = 8'd100; step(); start = 1'b0;
        cancel = 1'b1; step(); cancel = 1'b0;
        chk("c0_busy", int'(busy), 0);
        chk("c0_done", int'(done_money_in), 0);

        // reset while PAID
        start = 1'b1; price = 8'd5; step(); start = 1'b0;
        coin_valid = 1'b1; coin_type = 2'd0; step(); coin_valid = 1'b0;
        chk("rp_done", int'(done_money_in), 1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rp_done0", int'(done_money_in), 0);
        chk("rp_busy", int'(busy), 0);
        chk("rp_stock", int'({dut.stock[3], dut.stock[2], dut.stock[1], dut.stock[0]}), 16'h5555);

        // randomized traffic
        repeat (4000) begin
            reset      = ($urandom_range(0, 999) < 3);
            start      = ($urandom_range(0, 7) == 0);
            price      = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 120)) : 8'($urandom_range(0, 255));
            coin_valid = ($urandom_range(0, 9) < 4);
            coin_type  = 2'($urandom_range(0, 3));
            cancel     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 5) == 0) done_change_maker = ~done_change_maker;
            half_dollar = 4'($urandom_range(0, 6));
            quarter     = 4'($urandom_range(0, 6));
            dime        = 4'($urandom_range(0, 6));
            nickel      = 4'($urandom_range(0, 6));
            step();
        end
        reset = 1'b0; start = 1'b0; coin_valid = 1'b0; cancel = 1'b0;
        step(); step();
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
